// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FIN
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Per-digit double-dabble correction: digits of 5..9 get +3 before the shift.
module bcd_add3_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with optional leading-zero blanking applied at result load.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int W        = 16,
  parameter int DIGITS   = 5,
  parameter int BLANK_LZ = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [W-1:0]        BIN,
  output logic                BUSY,
  output logic                DONE,
  output logic [4*DIGITS-1:0] BCD,
  output logic                OVF
);

  localparam int CW = cnt_width(W);
  localparam int BW = 4 * DIGITS;

  state_t          state, state_nxt;
  logic [W-1:0]    bin_sr;
  logic [BW-1:0]   digit_sr;
  logic [BW-1:0]   digit_adj;
  logic [BW-1:0]   bcd_blank;
  logic            ovf_acc;
  logic [CW-1:0]   cnt;
  logic            done_r;
  logic [BW-1:0]   bcd_r;
  logic            ovf_r;
  logic            lead;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3_adj u_adj (
      .d (digit_sr[4*g +: 4]),
      .q (digit_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (START) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == CW'(1)) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Blank from the top digit down while everything above is still zero.
  always_comb begin
    bcd_blank = digit_sr;
    lead      = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      if (lead && digit_sr[4*i +: 4] == 4'd0) bcd_blank[4*i +: 4] = BLANK_CODE;
      else lead = 1'b0;
    end
    if (BLANK_LZ == 0) bcd_blank = digit_sr;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      bin_sr   <= '0;
      digit_sr <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
      done_r   <= 1'b0;
      bcd_r    <= '0;
      ovf_r    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= (state == ST_FIN);
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            bin_sr   <= BIN;
            digit_sr <= '0;
            ovf_acc  <= 1'b0;
            cnt      <= CW'(W);
          end
        end
        ST_SHIFT: begin
          // Top adjusted bit leaves the digit chain and only feeds overflow.
          digit_sr <= {digit_adj[BW-2:0], bin_sr[W-1]};
          bin_sr   <= bin_sr << 1;
          ovf_acc  <= ovf_acc | digit_adj[BW-1];
          cnt      <= cnt - CW'(1);
        end
        ST_FIN: begin
          bcd_r <= bcd_blank;
          ovf_r <= ovf_acc;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state != ST_IDLE);
  assign DONE = done_r;
  assign BCD  = bcd_r;
  assign OVF  = ovf_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: three converter configurations driven in lockstep.
module tb_bin_to_bcd_seq;

  logic        CLK = 1'b0;
  logic        RST, START;
  logic [15:0] BIN;

  logic        busy0, done0, ovf0;
  logic [19:0] bcd0;
  logic        busy1, done1, ovf1;
  logic [19:0] bcd1;
  logic        busy2, done2, ovf2;
  logic [15:0] bcd2;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  bin_to_bcd_seq #(.W(16), .DIGITS(5), .BLANK_LZ(0)) dut0 (
    .CLK(CLK), .RST(RST), .START(START), .BIN(BIN),
    .BUSY(busy0), .DONE(done0), .BCD(bcd0), .OVF(ovf0));
  bin_to_bcd_seq #(.W(16), .DIGITS(5), .BLANK_LZ(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START), .BIN(BIN),
    .BUSY(busy1), .DONE(done1), .BCD(bcd1), .OVF(ovf1));
  bin_to_bcd_seq #(.W(16), .DIGITS(4), .BLANK_LZ(1)) dut2 (
    .CLK(CLK), .RST(RST), .START(START), .BIN(BIN),
    .BUSY(busy2), .DONE(done2), .BCD(bcd2), .OVF(ovf2));

  typedef struct {
    logic [15:0] bin;
    logic [19:0] e0;
    logic [19:0] e1;
    logic [15:0] e2;
    logic        ovf2;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Decimal digits by division, then blanking by scanning the digit list.
  function automatic logic [20:0] ref_conv(input int unsigned v, input int nd, input bit blank);
    logic [19:0] r;
    int unsigned p, x;
    bit lead, ovf;
    r = '0;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    ovf = (v >= p);
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    if (blank) begin
      lead = 1'b1;
      for (int i = nd - 1; i >= 1; i--) begin
        if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
    return {ovf, r};
  endfunction

  // Issue one START and count edges until DONE; -1 on timeout.
  task automatic conv(input logic [15:0] v, output int lat);
    @(negedge CLK);
    START = 1'b1;
    BIN   = v;
    @(posedge CLK);
    #1;
    START = 1'b0;
    BIN   = 16'($urandom);
    lat   = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK);
      #1;
      if (done0) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_model(input logic [15:0] v);
    logic [20:0] r0, r1, r2;
    r0 = ref_conv(v, 5, 1'b0);
    r1 = ref_conv(v, 5, 1'b1);
    r2 = ref_conv(v, 4, 1'b1);
    check("rnd_bcd0", 32'(bcd0), 32'(r0[19:0]));
    check("rnd_ovf0", 32'(ovf0), 32'(r0[20]));
    check("rnd_bcd1", 32'(bcd1), 32'(r1[19:0]));
    check("rnd_ovf1", 32'(ovf1), 32'(r1[20]));
    check("rnd_bcd2", 32'(bcd2), 32'(r2[15:0]));
    check("rnd_ovf2", 32'(ovf2), 32'(r2[20]));
    check("rnd_done_sync", 32'({done1, done2}), 32'(2'b11));
  endtask

  initial begin
    int lat, ndone, first_at;
    int at[3];
    logic [15:0] v;

    vecs[0] = '{16'd1234,  20'h01234, 20'hF1234, 16'h1234, 1'b0};
    vecs[1] = '{16'd0,     20'h00000, 20'hFFFF0, 16'hFFF0, 1'b0};
    vecs[2] = '{16'd65535, 20'h65535, 20'h65535, 16'h5535, 1'b1};
    vecs[3] = '{16'd12345, 20'h12345, 20'h12345, 16'h2345, 1'b1};
    vecs[4] = '{16'd9999,  20'h09999, 20'hF9999, 16'h9999, 1'b0};
    vecs[5] = '{16'd10000, 20'h10000, 20'h10000, 16'hFFF0, 1'b1};
    vecs[6] = '{16'd9,     20'h00009, 20'hFFFF9, 16'hFFF9, 1'b0};
    vecs[7] = '{16'd100,   20'h00100, 20'hFF100, 16'hF100, 1'b0};

    RST = 1'b1; START = 1'b0; BIN = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rst_busy", 32'({busy0, busy1, busy2}), 32'(0));
    check("rst_done", 32'({done0, done1, done2}), 32'(0));
    check("rst_bcd0", 32'(bcd0), 32'(0));
    check("rst_bcd2", 32'(bcd2), 32'(0));
    check("rst_ovf",  32'({ovf0, ovf1, ovf2}), 32'(0));

    foreach (vecs[k]) begin
      conv(vecs[k].bin, lat);
      check("vec_latency", 32'(lat), 32'(17));
      check("vec_bcd0", 32'(bcd0), 32'(vecs[k].e0));
      check("vec_ovf0", 32'(ovf0), 32'(0));
      check("vec_bcd1", 32'(bcd1), 32'(vecs[k].e1));
      check("vec_bcd2", 32'(bcd2), 32'(vecs[k].e2));
      check("vec_ovf2", 32'(ovf2), 32'(vecs[k].ovf2));
      @(posedge CLK);
      #1;
      check("vec_done_width", 32'(done0), 32'(0));
      check("vec_busy_after", 32'(busy0), 32'(0));
    end

    // START pulses while busy must be ignored.
    @(negedge CLK);
    START = 1'b1; BIN = 16'd1234;
    @(posedge CLK);
    #1;
    START = 1'b0; BIN = '0;
    ndone = 0; first_at = -1;
    for (int n = 1; n <= 40; n++) begin
      START = (n == 3 || n == 17);
      if (START) BIN = 16'd7;
      @(posedge CLK);
      #1;
      if (n == 3 || n == 16) check("busy_during", 32'(busy0), 32'(1));
      if (done0) begin
        ndone++;
        if (first_at < 0) first_at = n;
        check("ign_bcd0", 32'(bcd0), 32'(20'h01234));
      end
    end
    START = 1'b0;
    check("ign_ndone", 32'(ndone), 32'(1));
    check("ign_done_at", 32'(first_at), 32'(17));

    // START held high re-triggers every W+2 cycles.
    @(negedge CLK);
    START = 1'b1; BIN = 16'd1234;
    ndone = 0;
    for (int n = 1; n <= 80 && ndone < 3; n++) begin
      @(posedge CLK);
      #1;
      if (done0) begin
        at[ndone] = n;
        ndone++;
        check("held_bcd0", 32'(bcd0), 32'(20'h01234));
      end
    end
    START = 1'b0;
    check("held_ndone", 32'(ndone), 32'(3));
    if (ndone == 3) begin
      check("held_gap1", 32'(at[1] - at[0]), 32'(18));
      check("held_gap2", 32'(at[2] - at[1]), 32'(18));
    end
    @(posedge CLK);
    #1;
    check("held_idle", 32'(busy0), 32'(0));

    // Reset mid-conversion aborts with no DONE and clears BCD.
    conv(16'd500, lat);
    check("c500_bcd0", 32'(bcd0), 32'(20'h00500));
    @(negedge CLK);
    START = 1'b1; BIN = 16'd42;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("abort_busy", 32'(busy0), 32'(0));
    check("abort_done", 32'(done0), 32'(0));
    check("abort_bcd0", 32'(bcd0), 32'(0));
    ndone = 0;
    repeat (25) begin
      @(posedge CLK);
      #1;
      if (done0 || done1 || done2) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'(0));
    conv(16'd42, lat);
    check("c42_latency", 32'(lat), 32'(17));
    check("c42_bcd0", 32'(bcd0), 32'(20'h00042));
    check("c42_bcd1", 32'(bcd1), 32'(20'hFFF42));
    check("c42_bcd2", 32'(bcd2), 32'(16'hFF42));

    // Random sweep against the arithmetic model.
    for (int k = 0; k < 2000; k++) begin
      v = 16'($urandom_range(0, 65535));
      conv(v, lat);
      check("rnd_latency", 32'(lat), 32'(17));
      check_model(v);
      @(posedge CLK);
      #1;
      check("rnd_done_width", 32'({done0, done1, done2}), 32'(0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
